// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the second-generation I2C slave.
//   i2c_state_t    : protocol FSM state encoding
//   I2C_ACK/NACK   : SDA level during the acknowledge bit
//   I2C_IDLE_BYTE  : byte served to a reading master when the TX FIFO is empty
// ----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } i2c_state_t;

    localparam logic       I2C_ACK       = 1'b0;
    localparam logic       I2C_NACK      = 1'b1;
    localparam logic [7:0] I2C_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/i2c_slave_gen2_if.sv
// ----------------------------------------------------------------------------
// i2c_slave_gen2_if
// Bundles the I2C pin pair and the host-side FIFO handshakes of the slave.
//   slave  modport : seen from i2c_slave_gen2
//   master modport : seen from whatever drives the bus pins and the host side
// Signals:
//   scl, sda_in             bus pins as read back from the wired bus
//   sda_out                 open-drain drive (0 pulls low, 1 releases)
//   write_enable/write_data push into the TX FIFO
//   fifo_empty/fifo_full    TX FIFO flags
//   read_enable/read_data   pop / show-ahead head of the RX FIFO
//   rx_empty/rx_full        RX FIFO flags
//   busy, tx_underrun       transfer status
// ----------------------------------------------------------------------------
interface i2c_slave_gen2_if;

    logic       scl;
    logic       sda_in;
    logic       sda_out;
    logic       write_enable;
    logic [7:0] write_data;
    logic       fifo_empty;
    logic       fifo_full;
    logic       read_enable;
    logic [7:0] read_data;
    logic       rx_empty;
    logic       rx_full;
    logic       busy;
    logic       tx_underrun;

    modport slave (
        input  scl, sda_in, write_enable, write_data, read_enable,
        output sda_out, fifo_empty, fifo_full, read_data, rx_empty, rx_full,
               busy, tx_underrun
    );

    modport master (
        output scl, sda_in, write_enable, write_data, read_enable,
        input  sda_out, fifo_empty, fifo_full, read_data, rx_empty, rx_full,
               busy, tx_underrun
    );

endinterface

// File: rtl/i2c_sync_fifo.sv
// ----------------------------------------------------------------------------
// i2c_sync_fifo
// Single-clock show-ahead FIFO used for both the TX and RX byte queues.
//   clk, rst    clock / synchronous active-high reset (discards contents)
//   push        write push_data (ignored when full)
//   pop         drop the head entry (ignored when empty)
//   head_data   registered head of queue, 0 when empty
//   empty/full  occupancy flags, valid the cycle after a push/pop
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module i2c_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_after_pop;
    logic [AW:0]      count_next;
    logic [WIDTH-1:0] head_reg;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push         = push && (count_reg != FULL_COUNT);
        do_pop          = pop  && (count_reg != '0);
        rd_ptr_next     = rd_ptr_reg + AW'(do_pop);
        count_after_pop = count_reg - (AW+1)'(do_pop);
        count_next      = count_after_pop + (AW+1)'(do_push);
    end

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(do_push);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            // The head is a registered read of the next read slot. When the
            // queue would otherwise be empty the slot is being written this
            // very cycle, so the incoming word is forwarded instead.
            if (count_next == '0) begin
                head_reg <= '0;
            end else if (do_push && (count_after_pop == '0)) begin
                head_reg <= push_data;
            end else begin
                head_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign head_data = head_reg;
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == FULL_COUNT);

endmodule

// File: rtl/i2c_slave_gen2.sv
// ----------------------------------------------------------------------------
// i2c_slave_gen2
// Address-matching I2C target. Master writes are pushed into an RX FIFO,
// master reads are served from a TX FIFO loaded by the host.
//   clk, rst   system clock / synchronous active-high reset
//   bus        i2c_slave_gen2_if.slave: scl/sda pins plus the host-side
//              TX push, RX pop, FIFO flags, busy and sticky tx_underrun
// Parameters: SLAVE_ADDR (7-bit address), TX_DEPTH, RX_DEPTH (powers of 2).
// ----------------------------------------------------------------------------
module i2c_slave_gen2
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         TX_DEPTH   = 8,
    parameter int         RX_DEPTH   = 8
) (
    input  logic             clk,
    input  logic             rst,
    i2c_slave_gen2_if.slave  bus
);

    // ------------------------------------------------------------------
    // Pin conditioning: two-flop synchroniser plus one delayed copy for
    // edge detection. Index 1 = scl, index 0 = sda. Reset to the idle
    // (released) bus level so no spurious edge appears after reset.
    // ------------------------------------------------------------------
    logic [1:0] pin_raw;
    logic [1:0] pin_sync;
    logic [1:0] pin_prev;

    assign pin_raw = {bus.scl, bus.sda_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            logic prev_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    meta_reg <= 1'b1;
                    sync_reg <= 1'b1;
                    prev_reg <= 1'b1;
                end else begin
                    meta_reg <= pin_raw[gi];
                    sync_reg <= meta_reg;
                    prev_reg <= sync_reg;
                end
            end

            assign pin_sync[gi] = sync_reg;
            assign pin_prev[gi] = prev_reg;
        end
    endgenerate

    logic scl_sync;
    logic sda_sync;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    always_comb begin
        scl_sync  = pin_sync[1];
        sda_sync  = pin_sync[0];
        scl_rise  = pin_sync[1] & ~pin_prev[1];
        scl_fall  = ~pin_sync[1] & pin_prev[1];
        // SDA may only move under a steady-high SCL for START/STOP.
        start_det = pin_sync[1] & pin_prev[1] & pin_prev[0] & ~pin_sync[0];
        stop_det  = pin_sync[1] & pin_prev[1] & ~pin_prev[0] & pin_sync[0];
    end

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    logic [7:0] tx_head;
    logic       tx_empty;
    logic       tx_pop;
    logic       rx_full;
    logic       rx_push_reg;
    logic [7:0] shift_reg;

    i2c_sync_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.write_enable),
        .push_data (bus.write_data),
        .pop       (tx_pop),
        .head_data (tx_head),
        .empty     (tx_empty),
        .full      (bus.fifo_full)
    );

    // The received byte stays in shift_reg until the next RX_BYTE rising
    // edge, so it is still valid when the registered push fires.
    i2c_sync_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push_reg),
        .push_data (shift_reg),
        .pop       (bus.read_enable),
        .head_data (bus.read_data),
        .empty     (bus.rx_empty),
        .full      (rx_full)
    );

    assign bus.fifo_empty = tx_empty;
    assign bus.rx_full    = rx_full;

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    i2c_state_t state_reg;
    logic [2:0] bit_cnt_reg;
    logic       sda_out_reg;
    logic       busy_reg;
    logic       underrun_reg;
    logic       rw_reg;
    // ACK sub-phase: in ADDR_ACK/RX_ACK set once the ACK is being driven;
    // in TX_ACK set once the master's ACK has been sampled.
    logic       phase_reg;
    logic [7:0] tx_load_byte;

    assign tx_load_byte = tx_empty ? I2C_IDLE_BYTE : tx_head;

    // A TX byte is fetched on the SCL fall that ends either the address
    // ACK of a read or a master ACK of the previous byte.
    always_comb begin
        tx_pop = 1'b0;
        if (scl_fall && phase_reg) begin
            if ((state_reg == ADDR_ACK) && rw_reg) begin
                tx_pop = 1'b1;
            end
            if (state_reg == TX_ACK) begin
                tx_pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            sda_out_reg  <= 1'b1;
            busy_reg     <= 1'b0;
            underrun_reg <= 1'b0;
            rw_reg       <= 1'b0;
            phase_reg    <= 1'b0;
            rx_push_reg  <= 1'b0;
        end else begin
            rx_push_reg <= 1'b0;
            if (stop_det) begin
                state_reg   <= IDLE;
                sda_out_reg <= 1'b1;
                busy_reg    <= 1'b0;
                phase_reg   <= 1'b0;
            end else if (start_det) begin
                state_reg    <= ADDR;
                bit_cnt_reg  <= '0;
                sda_out_reg  <= 1'b1;
                busy_reg     <= 1'b0;
                phase_reg    <= 1'b0;
                underrun_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        sda_out_reg <= 1'b1;
                    end

                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg   <= {shift_reg[6:0], sda_sync};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                // Bits 7:1 already sit in shift_reg[6:0];
                                // the bit arriving now is R/W.
                                if (shift_reg[6:0] == SLAVE_ADDR) begin
                                    state_reg <= ADDR_ACK;
                                    rw_reg    <= sda_sync;
                                    busy_reg  <= 1'b1;
                                    phase_reg <= 1'b0;
                                end else begin
                                    state_reg   <= WAIT_STOP;
                                    sda_out_reg <= I2C_NACK;
                                end
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!phase_reg) begin
                                sda_out_reg <= I2C_ACK;
                                phase_reg   <= 1'b1;
                            end else begin
                                phase_reg   <= 1'b0;
                                bit_cnt_reg <= '0;
                                if (rw_reg) begin
                                    state_reg   <= TX_BYTE;
                                    shift_reg   <= tx_load_byte;
                                    sda_out_reg <= tx_load_byte[7];
                                    if (tx_empty) begin
                                        underrun_reg <= 1'b1;
                                    end
                                end else begin
                                    state_reg   <= RX_BYTE;
                                    sda_out_reg <= 1'b1;
                                end
                            end
                        end
                    end

                    RX_BYTE: begin
                        if (scl_rise) begin
                            shift_reg   <= {shift_reg[6:0], sda_sync};
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                if (rx_full) begin
                                    state_reg   <= WAIT_STOP;
                                    busy_reg    <= 1'b0;
                                    sda_out_reg <= I2C_NACK;
                                end else begin
                                    state_reg <= RX_ACK;
                                    phase_reg <= 1'b0;
                                end
                            end
                        end
                    end

                    RX_ACK: begin
                        if (scl_fall) begin
                            if (!phase_reg) begin
                                sda_out_reg <= I2C_ACK;
                                rx_push_reg <= 1'b1;
                                phase_reg   <= 1'b1;
                            end else begin
                                sda_out_reg <= 1'b1;
                                phase_reg   <= 1'b0;
                                bit_cnt_reg <= '0;
                                state_reg   <= RX_BYTE;
                            end
                        end
                    end

                    TX_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt_reg == 3'd7) begin
                                sda_out_reg <= 1'b1;
                                phase_reg   <= 1'b0;
                                state_reg   <= TX_ACK;
                            end else begin
                                sda_out_reg <= shift_reg[6];
                                shift_reg   <= {shift_reg[6:0], 1'b0};
                                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            end
                        end
                    end

                    TX_ACK: begin
                        if (scl_rise) begin
                            if (sda_sync == I2C_ACK) begin
                                phase_reg <= 1'b1;
                            end else begin
                                state_reg <= WAIT_STOP;
                                busy_reg  <= 1'b0;
                            end
                        end else if (scl_fall && phase_reg) begin
                            phase_reg   <= 1'b0;
                            bit_cnt_reg <= '0;
                            state_reg   <= TX_BYTE;
                            shift_reg   <= tx_load_byte;
                            sda_out_reg <= tx_load_byte[7];
                            if (tx_empty) begin
                                underrun_reg <= 1'b1;
                            end
                        end
                    end

                    WAIT_STOP: begin
                        sda_out_reg <= 1'b1;
                        busy_reg    <= 1'b0;
                    end

                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sda_out     = sda_out_reg;
    assign bus.busy        = busy_reg;
    assign bus.tx_underrun = underrun_reg;

    // scl_sync is only consumed through the edge/START/STOP terms.
    logic unused_ok;
    assign unused_ok = scl_sync;

endmodule
